// File: rtl/sdram_rr_arbiter_if.sv
// Bus bundle between the bus masters, the round-robin arbiter and the SDRAM controller.
// The slave modport is the arbiter's view of the bundle. The master modport is the surrounding system's view.
interface sdram_rr_arbiter_if #(
    parameter int NUM_MASTERS = 6
);
    logic [NUM_MASTERS-1:0]    m_request;
    logic [NUM_MASTERS-1:0]    m_ready;
    logic [NUM_MASTERS-1:0]    m_write;
    logic [NUM_MASTERS-1:0]    m_burst;
    logic [NUM_MASTERS*26-1:0] m_address;
    logic [NUM_MASTERS*32-1:0] m_wdata;
    logic [NUM_MASTERS*4-1:0]  m_wstrb;
    logic [NUM_MASTERS-1:0]    m_rvalid;
    logic [NUM_MASTERS-1:0]    m_complete;
    logic [25:0]               m_raddress;
    logic [31:0]               m_rdata;
    logic [2:0]                sdram_request;
    logic                      sdram_ready;
    logic [25:0]               sdram_address;
    logic                      sdram_write;
    logic                      sdram_burst;
    logic [3:0]                sdram_wstrb;
    logic [31:0]               sdram_wdata;
    logic [25:0]               sdram_raddress;
    logic [31:0]               sdram_rdata;
    logic [2:0]                sdram_rvalid;
    logic                      sdram_complete;
    logic                      err_bad_id;

    modport slave (
        input  m_request, m_write, m_burst, m_address, m_wdata, m_wstrb,
        input  sdram_ready, sdram_raddress, sdram_rdata, sdram_rvalid, sdram_complete,
        output m_ready, m_rvalid, m_complete, m_raddress, m_rdata,
        output sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
        output err_bad_id
    );

    modport master (
        output m_request, m_write, m_burst, m_address, m_wdata, m_wstrb,
        output sdram_ready, sdram_raddress, sdram_rdata, sdram_rvalid, sdram_complete,
        input  m_ready, m_rvalid, m_complete, m_raddress, m_rdata,
        input  sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wstrb, sdram_wdata,
        input  err_bad_id
    );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// Shares one SDRAM controller port. Master 0 has run-limited high priority, and the others are served round-robin.
// Read returns are demultiplexed to the masters by id.
module sdram_rr_arbiter #(
    parameter int NUM_MASTERS = 6,
    parameter int MAX_HP_RUN  = 4
) (
    input  logic                clk,
    input  logic                reset,
    sdram_rr_arbiter_if.slave   bus
);
    logic [2:0]             rr_ptr_r;
    logic [2:0]             rr_next_s;
    logic [3:0]             hp_run_r;
    logic [3:0]             hp_next_s;
    logic                   others_s;
    logic                   grant_hp_s;
    logic                   found_s;
    logic                   grant_any_s;
    logic [2:0]             winner_s;
    logic                   bad_id_s;

    // The candidate at scan offset off from base, wrapping from the last master back to master 1.
    function automatic logic [2:0] rr_index(input logic [2:0] base, input int off);
        int sum_v;
        sum_v = int'(base) + off;
        sum_v = (sum_v > NUM_MASTERS - 1) ? sum_v - (NUM_MASTERS - 1) : sum_v;
        return 3'(sum_v);
    endfunction

    // Winner selection: master 0 unless its run limit is hit, then the first round-robin requester.
    always_comb begin
        others_s   = |bus.m_request[NUM_MASTERS-1:1];
        grant_hp_s = bus.m_request[0] && (!others_s || (hp_run_r < 4'(MAX_HP_RUN)));
        found_s    = 1'b0;
        winner_s   = 3'd0;
        for (int off = 0; off < NUM_MASTERS - 1; off++) begin
            if (!grant_hp_s && !found_s && bus.m_request[rr_index(rr_ptr_r, off)]) begin
                found_s  = 1'b1;
                winner_s = rr_index(rr_ptr_r, off);
            end else begin
                found_s  = found_s;
            end
        end
        grant_any_s = grant_hp_s || found_s;
    end

    // Next values of the round-robin pointer and the high-priority run counter.
    always_comb begin
        rr_next_s = rr_ptr_r;
        hp_next_s = hp_run_r;
        if (!bus.sdram_ready) begin
            rr_next_s = rr_ptr_r;
        end else if (grant_hp_s) begin
            hp_next_s = !others_s ? 4'd0 : ((hp_run_r == 4'd15) ? 4'd15 : hp_run_r + 4'd1);
        end else if (found_s) begin
            rr_next_s = (winner_s == 3'(NUM_MASTERS - 1)) ? 3'd1 : winner_s + 3'd1;
            hp_next_s = 4'd0;
        end else begin
            hp_next_s = hp_run_r;
        end
    end

    // Same-cycle one-hot grant; suppressed while the controller is busy or reset is active.
    always_comb begin
        bus.m_ready = {NUM_MASTERS{1'b0}};
        if (bus.sdram_ready && grant_any_s && !reset) begin
            bus.m_ready[winner_s] = 1'b1;
        end else begin
            bus.m_ready = {NUM_MASTERS{1'b0}};
        end
    end

    // Arbiter state and registered request fields toward the controller.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r          <= 3'd1;
            hp_run_r          <= 4'd0;
            bus.sdram_request <= 3'd0;
            bus.sdram_address <= 26'd0;
            bus.sdram_write   <= 1'b0;
            bus.sdram_burst   <= 1'b0;
            bus.sdram_wstrb   <= 4'd0;
            bus.sdram_wdata   <= 32'd0;
        end else if (bus.sdram_ready) begin
            rr_ptr_r <= rr_next_s;
            hp_run_r <= hp_next_s;
            if (grant_any_s) begin
                bus.sdram_request <= winner_s + 3'd1;
                bus.sdram_address <= bus.m_address[int'(winner_s)*26 +: 26];
                bus.sdram_write   <= bus.m_write[winner_s];
                bus.sdram_burst   <= bus.m_burst[winner_s];
                bus.sdram_wstrb   <= bus.m_wstrb[int'(winner_s)*4 +: 4];
                bus.sdram_wdata   <= bus.m_wdata[int'(winner_s)*32 +: 32];
            end else begin
                bus.sdram_request <= 3'd0;
                bus.sdram_address <= 26'd0;
                bus.sdram_write   <= 1'b0;
                bus.sdram_burst   <= 1'b0;
                bus.sdram_wstrb   <= 4'd0;
                bus.sdram_wdata   <= 32'd0;
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
            hp_run_r <= hp_run_r;
        end
    end

    // Read return decode by id; ids above NUM_MASTERS go nowhere.
    always_comb begin
        bus.m_rvalid   = {NUM_MASTERS{1'b0}};
        bus.m_complete = {NUM_MASTERS{1'b0}};
        bad_id_s       = bus.sdram_rvalid > 3'(NUM_MASTERS);
        if ((bus.sdram_rvalid != 3'd0) && !bad_id_s) begin
            bus.m_rvalid[bus.sdram_rvalid - 3'd1]   = 1'b1;
            bus.m_complete[bus.sdram_rvalid - 3'd1] = bus.sdram_complete;
        end else begin
            bus.m_rvalid   = {NUM_MASTERS{1'b0}};
        end
    end

    assign bus.m_raddress = bus.sdram_raddress;
    assign bus.m_rdata    = bus.sdram_rdata;

    // Sticky flag for an out-of-range read return id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.err_bad_id <= 1'b0;
        end else if (bad_id_s) begin
            bus.err_bad_id <= 1'b1;
        end else begin
            bus.err_bad_id <= bus.err_bad_id;
        end
    end
endmodule
